// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: bus encodings, pipeline entry type and store lane helpers.
package mem_responder_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {BUS_NONE = 2'h0, BUS_LOAD = 2'h1, BUS_STORE = 2'h2} bus_command_t;
  typedef enum logic [1:0] {BYTE = 2'h0, HALF = 2'h1, WORD = 2'h2, DOUBLE = 2'h3} mem_size_t;
  typedef struct packed {
    logic        valid;
    logic [3:0]  tag;
    logic [63:0] data;
  } mem_pipe_entry_t;
  function automatic logic aligned(mem_size_t size, logic [2:0] off);
    return size == BYTE ? 1'b1 : size == HALF ? !off[0] : size == WORD ? off[1:0] == 2'b00 : off == 3'b000;
  endfunction
  function automatic logic [7:0] byte_mask(mem_size_t size, logic [2:0] off);
    return size == BYTE ? 8'h01 << off : size == HALF ? 8'h03 << off : size == WORD ? 8'h0f << off : 8'hff;
  endfunction
endpackage

// File: rtl/mem_tag_alloc.sv
// mem_tag_alloc: tracks busy load tags 1..15 and offers the lowest free one.
module mem_tag_alloc (
  input  logic       clk,
  input  logic       reset,
  input  logic       alloc_i,
  input  logic       free_i,
  input  logic [3:0] free_tag_i,
  output logic [3:0] tag_o
);
  logic [15:1] busy_q, busy_d;
  // A tag being returned this cycle is still busy, so it is never offered.
  always_comb begin
    tag_o = 4'h0;
    busy_d = busy_q;
    for (int i = 15; i >= 1; i--)
      if (!busy_q[i]) tag_o = 4'(i);
    for (int i = 1; i <= 15; i++)
      busy_d[i] = (busy_q[i] && !(free_i && free_tag_i == 4'(i))) || (alloc_i && tag_o == 4'(i));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) busy_q <= '0;
    else busy_q <= busy_d;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: tagged memory endpoint returning loads after a fixed latency.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MEM_DWORDS  = 256,
  parameter int MEM_LATENCY = 4
) (
  input  logic [0:0]      clk,
  input  logic [0:0]      reset,
  input  logic [XLEN-1:0] proc2mem_addr,
  input  logic [63:0]     proc2mem_data,
  input  bus_command_t    proc2mem_command,
  input  mem_size_t       proc2mem_size,
  output logic [3:0]      mem2proc_response,
  output logic [63:0]     mem2proc_data,
  output logic [3:0]      mem2proc_tag
);
  localparam int IW = $clog2(MEM_DWORDS);
  logic [63:0]     mem_q [MEM_DWORDS];
  mem_pipe_entry_t pipe_q [MEM_LATENCY];
  mem_pipe_entry_t push_d;
  logic [IW-1:0]   idx;
  logic [2:0]      off;
  logic [3:0]      free_tag;
  logic [7:0]      mask;
  logic [63:0]     wdata;
  logic            load_acc, store_acc;
  logic            unused_addr;
  assign idx = proc2mem_addr[3 +: IW];
  assign off = proc2mem_addr[2:0];
  assign unused_addr = ^proc2mem_addr[XLEN-1:3+IW];
  assign load_acc = proc2mem_command == BUS_LOAD && free_tag != 4'h0;
  assign store_acc = proc2mem_command == BUS_STORE && aligned(proc2mem_size, off) && free_tag != 4'h0;
  assign mem2proc_response = (load_acc || store_acc) ? free_tag : 4'h0;
  assign mask = byte_mask(proc2mem_size, off);
  assign wdata = proc2mem_data << {off, 3'b000};
  // Idle slots are all-zero, so the last stage drives tag/data directly.
  assign push_d = load_acc ? '{valid: 1'b1, tag: free_tag, data: mem_q[idx]} : '0;
  assign mem2proc_tag = pipe_q[MEM_LATENCY-1].tag;
  assign mem2proc_data = pipe_q[MEM_LATENCY-1].data;
  mem_tag_alloc u_alloc (
    .clk        (clk),
    .reset      (reset),
    .alloc_i    (load_acc),
    .free_i     (pipe_q[MEM_LATENCY-1].valid),
    .free_tag_i (pipe_q[MEM_LATENCY-1].tag),
    .tag_o      (free_tag)
  );
  always_ff @(posedge clk)
    if (store_acc)
      for (int b = 0; b < 8; b++)
        if (mask[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < MEM_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= push_d;
      for (int i = 1; i < MEM_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of accept, store lanes, load latency and tag reuse.
module tb_mem_responder;
  import mem_responder_pkg::*;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  addr = '0;
  logic [63:0]  wdat = '0;
  bus_command_t cmd = BUS_NONE;
  mem_size_t    size = DOUBLE;
  logic [3:0]   response, tag;
  logic [63:0]  rdat;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  mem_responder #(.MEM_DWORDS(1024), .MEM_LATENCY(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .proc2mem_addr     (addr),
    .proc2mem_data     (wdat),
    .proc2mem_command  (cmd),
    .proc2mem_size     (size),
    .mem2proc_response (response),
    .mem2proc_data     (rdat),
    .mem2proc_tag      (tag)
  );
  task automatic check(input string t, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", t, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_chk(input string t);
    check({t, " tag"}, 64'(tag), 64'h0);
    check({t, " data"}, rdat, 64'h0);
  endtask
  task automatic drive(input bus_command_t c, input logic [31:0] a, input logic [63:0] d,
                       input mem_size_t s, input logic [3:0] er, input string t);
    cmd = c; addr = a; wdat = d; size = s;
    #1 check({t, " resp"}, 64'(response), 64'(er));
    tick();
    cmd = BUS_NONE;
  endtask
  task automatic load_chk(input logic [31:0] a, input logic [3:0] er, input logic [63:0] ed, input string t);
    drive(BUS_LOAD, a, 64'h0, DOUBLE, er, t);
    tick(); idle_chk({t, " +1"});
    tick(); idle_chk({t, " +2"});
    tick();
    check({t, " ret tag"}, 64'(tag), 64'(er));
    check({t, " ret data"}, rdat, ed);
    tick(); idle_chk({t, " after"});
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst resp", 64'(response), 64'h0);
      idle_chk("rst");
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("idle resp", 64'(response), 64'h0);
      idle_chk("idle");
    end
    drive(BUS_STORE, 32'h10, 64'hDEADBEEF00000010, DOUBLE, 4'd1, "st10");
    load_chk(32'h10, 4'd1, 64'hDEADBEEF00000010, "ld10");
    drive(BUS_STORE, 32'h1000, 64'hDEADBEEF00001000, DOUBLE, 4'd1, "st1000");
    drive(BUS_STORE, 32'h2000, 64'hFEEDFACE00002000, DOUBLE, 4'd1, "st2000");
    drive(BUS_LOAD, 32'h1000, 64'h0, DOUBLE, 4'd1, "b2b ld1");
    drive(BUS_LOAD, 32'h2000, 64'h0, DOUBLE, 4'd2, "b2b ld2");
    tick(); idle_chk("b2b +2");
    tick();
    check("b2b tag1", 64'(tag), 64'd1);
    check("b2b data1", rdat, 64'hDEADBEEF00001000);
    tick();
    check("b2b tag2", 64'(tag), 64'd2);
    check("b2b data2", rdat, 64'hFEEDFACE00002000);
    tick(); idle_chk("b2b after");
    load_chk(32'h3000, 4'd1, 64'hDEADBEEF00001000, "alias");
    drive(BUS_STORE, 32'h10, 64'h1111111111111111, DOUBLE, 4'd1, "st ones");
    drive(BUS_STORE, 32'h13, 64'hAB, BYTE, 4'd1, "st byte");
    load_chk(32'h10, 4'd1, 64'h11111111AB111111, "ld byte");
    drive(BUS_STORE, 32'h11, 64'hFFFF, HALF, 4'd0, "st half mis");
    load_chk(32'h10, 4'd1, 64'h11111111AB111111, "ld unchanged");
    drive(BUS_STORE, 32'h14, 64'h22222222, WORD, 4'd1, "st word");
    load_chk(32'h10, 4'd1, 64'h22222222AB111111, "ld word");
    for (int i = 0; i < 23; i++) begin
      if (i < 20) drive(BUS_LOAD, 32'h10, 64'h0, DOUBLE, 4'((i % 5) + 1), $sformatf("stream ld%0d", i));
      else tick();
      if (i >= 3) begin
        check($sformatf("stream ret tag%0d", i - 3), 64'(tag), 64'(((i - 3) % 5) + 1));
        check($sformatf("stream ret data%0d", i - 3), rdat, 64'h22222222AB111111);
      end else idle_chk($sformatf("stream early%0d", i));
    end
    tick(); idle_chk("stream after");
    drive(BUS_LOAD, 32'h10, 64'h0, DOUBLE, 4'd1, "pre-rst ld");
    tick();
    tick();
    reset = 1'b1;
    #1 idle_chk("mid rst");
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      idle_chk($sformatf("post rst %0d", i));
    end
    load_chk(32'h10, 4'd1, 64'h22222222AB111111, "post rst ld");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
